// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its branch target buffer.
package fetch_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Tag field sized for the smallest possible index; unused upper bits stay zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [1:0]  ctr;
  } pred_t;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST)  ? ST  : c + 2'b01;
    else       return (c == SNT) ? SNT : c - 2'b01;
  endfunction

endpackage

// File: rtl/fetch_predict_if.sv
// Fetch <-> decode / instruction-memory signal bundle.
interface fetch_predict_if;
  logic        FREEZE;
  logic        Redirect_valid;
  logic [31:0] Redirect_PC;
  logic        Update_valid;
  logic [31:0] Update_PC;
  logic        Update_taken;
  logic [31:0] Update_target;
  logic [31:0] Instr_address_2IM;
  logic [31:0] Instr_fIM;
  logic [31:0] Instr_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;
  logic        Branch_prediction_OUT;
  logic [31:0] Branch_prediction_addr_OUT;
  logic [1:0]  Branch_predictions_OUT;

  // master = fetch stage, slave = decode / memory side
  modport master (
    input  FREEZE, Redirect_valid, Redirect_PC,
           Update_valid, Update_PC, Update_taken, Update_target, Instr_fIM,
    output Instr_address_2IM, Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT,
           Branch_prediction_OUT, Branch_prediction_addr_OUT, Branch_predictions_OUT
  );
  modport slave (
    output FREEZE, Redirect_valid, Redirect_PC,
           Update_valid, Update_PC, Update_taken, Update_target, Instr_fIM,
    input  Instr_address_2IM, Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT,
           Branch_prediction_OUT, Branch_prediction_addr_OUT, Branch_predictions_OUT
  );
endinterface

// File: rtl/btb_table.sv
// Direct-mapped BTB: combinational lookup, synchronous update, async clear of valid bits.
module btb_table
  import fetch_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] lookup_pc,
  output pred_t       lookup,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int ENTRIES = 1 << IDX_BITS;

  btb_entry_t mem [ENTRIES];

  function automatic logic [IDX_BITS-1:0] idx_of(input logic [31:0] pc);
    return pc[IDX_BITS+1:2];
  endfunction

  function automatic logic [29:0] tag_of(input logic [31:0] pc);
    return 30'(pc >> (IDX_BITS + 2));
  endfunction

  btb_entry_t          le, ue;
  logic                lhit, uhit;
  logic [IDX_BITS-1:0] ui;

  always_comb begin
    le           = mem[idx_of(lookup_pc)];
    lhit         = le.valid && (le.tag == tag_of(lookup_pc));
    lookup.taken = lhit && le.ctr[1];
    lookup.target = lookup.taken ? le.target : 32'h0;
    lookup.ctr   = lhit ? le.ctr : WNT;
  end

  always_comb begin
    ui   = idx_of(upd_pc);
    ue   = mem[ui];
    uhit = ue.valid && (ue.tag == tag_of(upd_pc));
  end

  // Only valid bits are reset; tag/target/counter are qualified by valid.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ENTRIES; i++) mem[i].valid <= 1'b0;
    end else if (upd_valid) begin
      if (uhit) begin
        mem[ui].ctr <= ctr_step(ue.ctr, upd_taken);
        if (upd_taken) mem[ui].target <= upd_target;
      end else if (upd_taken) begin
        mem[ui] <= '{valid: 1'b1, tag: tag_of(upd_pc), target: upd_target, ctr: WT};
      end
    end
  end

endmodule

// File: rtl/fetch_predict.sv
// Fetch stage: PC register, next-PC selection and fetch/decode pipeline register.
module fetch_predict
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'hBFC00000,
  parameter int          BTB_INDEX_BITS = 4
) (
  input logic             CLK,
  input logic             RESET,
  fetch_predict_if.master bus
);

  logic [31:0] pc, pc_plus4, next_pc;
  pred_t       pred;

  btb_table #(.IDX_BITS(BTB_INDEX_BITS)) u_btb (
    .CLK        (CLK),
    .RESET      (RESET),
    .lookup_pc  (pc),
    .lookup     (pred),
    .upd_valid  (bus.Update_valid),
    .upd_pc     (bus.Update_PC),
    .upd_taken  (bus.Update_taken),
    .upd_target (bus.Update_target)
  );

  assign bus.Instr_address_2IM = pc;
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (bus.Redirect_valid)  next_pc = bus.Redirect_PC;
    else if (bus.FREEZE)     next_pc = pc;
    else if (pred.taken)     next_pc = pred.target;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc                             <= RESET_PC;
      bus.Instr_OUT                  <= NOP_INSTR;
      bus.Instr_PC_OUT               <= 32'h0;
      bus.Instr_PC_Plus4_OUT         <= 32'h0;
      bus.Branch_prediction_OUT      <= 1'b0;
      bus.Branch_prediction_addr_OUT <= 32'h0;
      bus.Branch_predictions_OUT     <= 2'b00;
    end else begin
      pc <= next_pc;
      // Redirect squashes whatever was fetched this cycle into a single bubble.
      if (bus.Redirect_valid) begin
        bus.Instr_OUT                  <= NOP_INSTR;
        bus.Instr_PC_OUT               <= 32'h0;
        bus.Instr_PC_Plus4_OUT         <= 32'h0;
        bus.Branch_prediction_OUT      <= 1'b0;
        bus.Branch_prediction_addr_OUT <= 32'h0;
        bus.Branch_predictions_OUT     <= 2'b00;
      end else if (!bus.FREEZE) begin
        bus.Instr_OUT                  <= bus.Instr_fIM;
        bus.Instr_PC_OUT               <= pc;
        bus.Instr_PC_Plus4_OUT         <= pc_plus4;
        bus.Branch_prediction_OUT      <= pred.taken;
        bus.Branch_prediction_addr_OUT <= pred.target;
        bus.Branch_predictions_OUT     <= pred.ctr;
      end
    end
  end

endmodule
